lock_sequencer: RTL



---
 rtl/lock_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/lock_sequencer.sv
// lock_sequencer: drives a serial combination lock from a parallel code request.
// It shifts the code MSB-first onto lock_x, returns the lock to idle after every
// attempt, reports pass/fail, and enforces a lockout after repeated failures.
module lock_sequencer #(
  parameter int CODE_LEN        = 6,
  parameter int MAX_FAIL        = 3,
  parameter int LOCKOUT_CYCLES  = 16,
  parameter int RECOVER_TIMEOUT = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CODE_LEN-1:0]           req_code,
  output logic                          lock_x,
  input  logic                          lock_ready,
  input  logic                          lock_unlock,
  input  logic                          lock_error,
  output logic                          resp_valid,
  output logic                          resp_ok,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count,
  output logic                          lockout,
  output logic                          fault
);

  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int IW   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int CMAX = (LOCKOUT_CYCLES > RECOVER_TIMEOUT) ? LOCKOUT_CYCLES : RECOVER_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] LAST_BIT = IW'(CODE_LEN - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(RECOVER_TIMEOUT - 1);
  localparam logic [CW-1:0] LO_LAST  = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FMAX     = FW'(MAX_FAIL);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT   = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] RECOVER = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;
  localparam logic [2:0] LOCKOUT = 3'd5;
  localparam logic [2:0] FAULT   = 3'd6;

  logic [2:0]          state, state_d;
  logic [CODE_LEN-1:0] code_q;
  logic [IW-1:0]       bit_idx;
  logic [CW-1:0]       cnt;
  logic                ok_q;
  logic                run_q;
  logic [FW-1:0]       fc_inc;
  logic                accept;

  // run_q keeps req_ready low while reset is held and for the first edge after it
  assign req_ready  = run_q && (state == IDLE) && lock_ready;
  assign accept     = req_valid && req_ready;
  // lock_x depends only on registered state so the lock never sees a comb loop
  assign lock_x     = (state == SHIFT) && code_q[bit_idx];
  assign resp_valid = (state == RESP);
  assign resp_ok    = (state == RESP) && ok_q;
  assign lockout    = (state == LOCKOUT);
  assign fault      = (state == FAULT);
  assign fc_inc     = (fail_count == FMAX) ? FMAX : fail_count + 1'b1;

  // Next-state selection; lock outputs only steer transitions
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (lock_error) state_d = RECOVER;
               else if (bit_idx == '0) state_d = CHECK;
      CHECK:   state_d = RECOVER;
      RECOVER: if (lock_ready) state_d = RESP;
               else if (cnt == REC_LAST) state_d = FAULT;
      RESP:    state_d = (!ok_q && fc_inc == FMAX) ? LOCKOUT : IDLE;
      LOCKOUT: if (cnt == LO_LAST) state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // State register plus the post-reset arm flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_d;
      run_q <= 1'b1;
    end
  end

  // Shared dwell counter for RECOVER and LOCKOUT, restarted on every state change
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                      cnt <= '0;
    else if (state_d != state)                       cnt <= '0;
    else if (state == RECOVER || state == LOCKOUT)   cnt <= cnt + 1'b1;
  end

  // Code capture, bit walk and pass/fail capture; an abort leaves ok_q at 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      code_q  <= '0;
      bit_idx <= '0;
      ok_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          code_q  <= req_code;
          bit_idx <= LAST_BIT;
          ok_q    <= 1'b0;
        end
        SHIFT: if (lock_error)           ok_q    <= 1'b0;
               else if (bit_idx != '0)   bit_idx <= bit_idx - 1'b1;
        CHECK:                           ok_q    <= lock_unlock;
        default: ;
      endcase
    end
  end

  // Consecutive failure count: cleared on success or when lockout expires
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fail_count <= '0;
    end else if (state == RESP) begin
      fail_count <= ok_q ? '0 : fc_inc;
    end else if (state == LOCKOUT && cnt == LO_LAST) begin
      fail_count <= '0;
    end
  end

endmodule
